// File: rtl/jno_pkg.sv
// rtl/jno_pkg.sv - shared types and constants for the JNO sequencer
//
// Purpose: FSM state encoding, the JNO opcode value, default phase lengths
//          and a small integer max helper used for counter sizing.
// Ports:   none (package)
package jno_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CHECK  = 2'd1,
    ST_OPEN   = 2'd2,
    ST_SETTLE = 2'd3
  } state_t;

  localparam logic [1:0] OP_JNO = 2'b01;

  localparam int DEF_CHECK_CYCLES = 8;
  localparam int DEF_OPEN_CYCLES  = 4;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// rtl/phase_timer.sv - loadable down-counter that flags the last cycle of a phase
//
// Purpose: counts the cycles of one phase; loaded with the phase length on
//          the edge that enters the phase, then decrements every clock.
// Ports:
//   clk    in  clock
//   reset  in  synchronous active-high reset
//   load   in  load the counter with `count` on this edge
//   count  in  W  phase length to load (>= 1)
//   expire out high during the final cycle of the loaded phase
module phase_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] count,
  output logic         expire
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= count;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  // A value of 1 means this is the last cycle of the phase; the counter
  // parks at 0 while idle so it never raises a stray expire.
  assign expire = (r_cnt == W'(1));

endmodule

// File: rtl/jno_sequencer.sv
// rtl/jno_sequencer.sv - cycle-counted controller for the jump-if-no-overflow path
//
// Purpose: accepts one decoded instruction at a time. Non-JNO opcodes bump the
//          PC and complete the next cycle; a JNO runs CHECK, OPEN and SETTLE
//          phases, then loads the PC with the target (no overflow) or PC+1.
// Ports:
//   clk            in   clock
//   reset          in   synchronous active-high reset
//   instr_valid    in   decode presents an instruction
//   instr_ready    out  block can accept (IDLE only)
//   instruct       in   2     opcode, 2'b01 = JNO
//   target         in   PC_W  jump destination, captured on accept
//   sta            in   overflow status, captured on accept
//   enable         out  high for the whole CHECK phase
//   enable_status  out  high in CHECK when captured status is clear
//   openpulse      out  high in OPEN when captured status is clear
//   done           out  one-cycle completion pulse
//   taken          out  jump performed, valid with done
//   pc             out  PC_W  current program counter
module jno_sequencer
  import jno_pkg::*;
#(
  parameter int CHECK_CYCLES = DEF_CHECK_CYCLES,
  parameter int OPEN_CYCLES  = DEF_OPEN_CYCLES,
  parameter int PC_W         = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            instr_valid,
  output logic            instr_ready,
  input  logic [1:0]      instruct,
  input  logic [PC_W-1:0] target,
  input  logic            sta,
  output logic            enable,
  output logic            enable_status,
  output logic            openpulse,
  output logic            done,
  output logic            taken,
  output logic [PC_W-1:0] pc
);

  localparam int CNT_W = $clog2(max_int(CHECK_CYCLES, OPEN_CYCLES) + 1);

  state_t            r_state;
  state_t            w_next;
  logic [PC_W-1:0]   r_pc;
  logic [PC_W-1:0]   r_tgt_q;
  logic              r_sta_q;
  logic              r_nj_done;
  logic              w_accept;
  logic              w_is_jno;
  logic              w_load;
  logic [CNT_W-1:0]  w_load_val;
  logic              w_expire;

  assign w_accept = instr_valid && (r_state == ST_IDLE);
  assign w_is_jno = (instruct == OP_JNO);

  phase_timer #(.W(CNT_W)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .load   (w_load),
    .count  (w_load_val),
    .expire (w_expire)
  );

  always_comb begin
    w_next     = r_state;
    w_load     = 1'b0;
    w_load_val = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept && w_is_jno) begin
          w_next     = ST_CHECK;
          w_load     = 1'b1;
          w_load_val = CNT_W'(CHECK_CYCLES);
        end
      end
      ST_CHECK: begin
        // The same timer is reloaded for OPEN on the CHECK expiry edge.
        if (w_expire) begin
          w_next     = ST_OPEN;
          w_load     = 1'b1;
          w_load_val = CNT_W'(OPEN_CYCLES);
        end
      end
      ST_OPEN: begin
        if (w_expire) begin
          w_next = ST_SETTLE;
        end
      end
      ST_SETTLE: w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_pc      <= '0;
      r_tgt_q   <= '0;
      r_sta_q   <= 1'b0;
      r_nj_done <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_nj_done <= w_accept && !w_is_jno;
      if (w_accept && w_is_jno) begin
        r_tgt_q <= target;
        r_sta_q <= sta;
      end
      if (w_accept && !w_is_jno) begin
        r_pc <= r_pc + PC_W'(1);
      end
      // PC is written on entry to SETTLE so it is already final alongside done.
      if ((r_state == ST_OPEN) && w_expire) begin
        r_pc <= r_sta_q ? (r_pc + PC_W'(1)) : r_tgt_q;
      end
    end
  end

  assign instr_ready   = (r_state == ST_IDLE);
  assign enable        = (r_state == ST_CHECK);
  assign enable_status = (r_state == ST_CHECK) && !r_sta_q;
  assign openpulse     = (r_state == ST_OPEN) && !r_sta_q;
  assign done          = (r_state == ST_SETTLE) || r_nj_done;
  assign taken         = (r_state == ST_SETTLE) && !r_sta_q;
  assign pc            = r_pc;

endmodule
